rot_select_seq: RTL

- Upstream sequencer for the three-digit "dE1" rotation display.
- Generates the 2-bit character-rotation select that the display mux stage consumes in place of SW[9:8].
- Advances the rotation automatically on a prescaled tick, or manually from a push-button step.
- Direction and run/pause come from switches.

---
 rtl/rot_pkg.sv | 40 ++++
 rtl/key_step_sync.sv | 87 ++++++++
 rtl/rot_select_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
// Shared definitions for the "dE1" rotation display. Both the rotation
// sequencer and the display mux stage import these encodings so they cannot
// disagree about what each select value means.
//
// Contents:
//   rot_sel_e          2-bit character-rotation select
//                      (ROT_DE1 / ROT_E1D / ROT_1DE; ROT_ILLEGAL is never driven)
//   TICK_DIV_DEFAULT   clock cycles per automatic advance (1 s at 50 MHz)
//   DB_CYCLES_DEFAULT  debounce stability window (20 ms at 50 MHz)
//   rot_next()         next rotation position for a given direction
// -----------------------------------------------------------------------------
package rot_pkg;

   typedef enum logic [1:0] {
      ROT_DE1     = 2'b00,
      ROT_E1D     = 2'b01,
      ROT_1DE     = 2'b10,
      ROT_ILLEGAL = 2'b11   // only reachable through an upset; recovered to ROT_DE1
   } rot_sel_e;

   localparam int TICK_DIV_DEFAULT  = 50_000_000;
   localparam int DB_CYCLES_DEFAULT = 1_000_000;

   // dir = 0 : dE1 -> E1d -> 1dE -> dE1
   // dir = 1 : dE1 -> 1dE -> E1d -> dE1
   function automatic rot_sel_e rot_next(input rot_sel_e sel, input logic dir);
      rot_sel_e nxt;
      nxt = ROT_DE1;
      case (sel)
         ROT_DE1: nxt = dir ? ROT_1DE : ROT_E1D;
         ROT_E1D: nxt = dir ? ROT_DE1 : ROT_1DE;
         ROT_1DE: nxt = dir ? ROT_E1D : ROT_DE1;
         default: nxt = ROT_DE1;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/key_step_sync.sv
// -----------------------------------------------------------------------------
// key_step_sync
// Turns an asynchronous, active-low push-button into a single-cycle step
// strobe: 2-flop synchroniser, optional debouncer, falling-edge detector.
// Reusable for any KEY input.
//
// Optional feature macro: ROT_DEBOUNCE_EN
//   defined   : the edge detector watches a debounced level that only follows
//               the synchronised input after DB_CYCLES consecutive differing
//               cycles (step latency DB_CYCLES+3 edges).
//   undefined : the edge detector watches the synchronised level directly
//               (step latency 3 edges); DB_CYCLES is ignored.
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   Resetn    in   asynchronous active-low reset
//   Step_n    in   raw active-low button (asynchronous)
//   step      out  one-cycle strobe per press (falling edge of the button)
// -----------------------------------------------------------------------------
module key_step_sync #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic CLOCK_50,
   input  logic Resetn,
   input  logic Step_n,
   output logic step
);

   // All button-side flops reset to 1, the idle-high level of the button, so
   // a button held through reset release still yields exactly one step.
   logic sync_meta;
   logic sync_lvl;
   logic key_lvl;    // level seen by the edge detector
   logic prev_lvl;   // key_lvl delayed by one cycle

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         sync_meta <= 1'b1;
         sync_lvl  <= 1'b1;
      end else begin
         sync_meta <= Step_n;
         sync_lvl  <= sync_meta;
      end
   end

`ifdef ROT_DEBOUNCE_EN
   localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [DB_W-1:0] db_cnt;
   logic            db_lvl;

   // db_cnt counts consecutive cycles in which the synchronised level
   // disagrees with the debounced one; agreement (a bounce back) clears it.
   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         db_cnt <= '0;
         db_lvl <= 1'b1;
      end else if (sync_lvl != db_lvl) begin
         if (db_cnt == DB_LAST) begin
            db_lvl <= sync_lvl;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   assign key_lvl = db_lvl;
`else
   assign key_lvl = sync_lvl;
`endif

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         prev_lvl <= 1'b1;
      end else begin
         prev_lvl <= key_lvl;
      end
   end

   // Press = 1 -> 0 transition; holding or releasing yields nothing further.
   assign step = prev_lvl & ~key_lvl;

endmodule

// File: rtl/rot_select_seq.sv
// -----------------------------------------------------------------------------
// rot_select_seq
// Upstream sequencer for the three-digit "dE1" rotation display. Produces the
// 2-bit character-rotation select used by the display mux in place of
// SW[9:8]. The rotation advances on a prescaled tick while Run is high, or by
// one position per press of the Step_n button. Dir picks the rotation sense.
//
// Optional feature macro: ROT_DEBOUNCE_EN (debounces Step_n inside
// key_step_sync; without it DB_CYCLES is ignored).
//
// Ports:
//   CLOCK_50  in   system clock, 50 MHz, rising edge
//   Resetn    in   asynchronous active-low reset
//   Run       in   1 = automatic advance, 0 = paused (asynchronous switch)
//   Dir       in   0 = forward, 1 = reverse (asynchronous switch)
//   Step_n    in   active-low push-button, one position per press
//   Ch_Sel    out  registered rotation select (00 dE1, 01 E1d, 10 1dE)
//   Adv       out  one-cycle pulse, high in the cycle after Ch_Sel changed
// -----------------------------------------------------------------------------
module rot_select_seq
   import rot_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEFAULT,
   parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       Run,
   input  logic       Dir,
   input  logic       Step_n,
   output logic [1:0] Ch_Sel,
   output logic       Adv
);

   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   // ---------------------------------------------------------------------
   // Switch synchronisers
   // ---------------------------------------------------------------------
   logic run_meta, run_s;
   logic dir_meta, dir_s;

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         run_meta <= 1'b0;
         run_s    <= 1'b0;
         dir_meta <= 1'b0;
         dir_s    <= 1'b0;
      end else begin
         run_meta <= Run;
         run_s    <= run_meta;
         dir_meta <= Dir;
         dir_s    <= dir_meta;
      end
   end

   // ---------------------------------------------------------------------
   // Button step strobe
   // ---------------------------------------------------------------------
   logic step;

   key_step_sync #(
      .DB_CYCLES (DB_CYCLES)
   ) u_key_step_sync (
      .CLOCK_50 (CLOCK_50),
      .Resetn   (Resetn),
      .Step_n   (Step_n),
      .step     (step)
   );

   // ---------------------------------------------------------------------
   // Prescaler: freezes (rather than clears) while paused, so a resume
   // finishes the interrupted period instead of starting a fresh one.
   // ---------------------------------------------------------------------
   logic [TW-1:0] presc;
   logic          tick;

   assign tick = run_s && (presc == TICK_LAST);

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         presc <= '0;
      end else if (run_s) begin
         presc <= tick ? '0 : presc + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Rotation state. A coincident tick and step merge into one advance.
   // ---------------------------------------------------------------------
   logic     adv;
   rot_sel_e sel;
   logic     adv_q;

   assign adv = tick | step;

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         sel   <= ROT_DE1;
         adv_q <= 1'b0;
      end else begin
         adv_q <= adv;
         if (sel == ROT_ILLEGAL) begin
            sel <= ROT_DE1;   // upset recovery takes priority over advancing
         end else if (adv) begin
            sel <= rot_next(sel, dir_s);
         end
      end
   end

   assign Ch_Sel = sel;
   assign Adv    = adv_q;

endmodule
